// File: rtl/multicycle_pkg.sv
// multicycle_pkg: shared encodings for the multicycle datapath controller.
//   - opcode constants decoded from instruction bits [31:26]
//   - controller state encoding (plain localparams, 4-bit)
//   - alu_op, alu_src_b and pc_src select encodings
//   - is_wait_state(): states that wait on the memory-ready handshake
`timescale 1ns/1ps
package multicycle_pkg;

  typedef logic [3:0] state_t;

  localparam state_t S_IDLE    = 4'd0;
  localparam state_t S_FETCH   = 4'd1;
  localparam state_t S_DECODE  = 4'd2;
  localparam state_t S_EXEC    = 4'd3;
  localparam state_t S_ALUWB   = 4'd4;
  localparam state_t S_MEMADR  = 4'd5;
  localparam state_t S_MEMRD   = 4'd6;
  localparam state_t S_MEMWB   = 4'd7;
  localparam state_t S_MEMWR   = 4'd8;
  localparam state_t S_BRANCH  = 4'd9;
  localparam state_t S_ADDI_EX = 4'd10;
  localparam state_t S_ADDI_WB = 4'd11;
  localparam state_t S_JUMP    = 4'd12;
  localparam state_t S_HALT    = 4'd13;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/ctrl_wait_timer.sv
// ctrl_wait_timer: bounded wait counter for the memory-ready handshake.
//   clk     : system clock
//   rst_n   : synchronous active-low reset, clears the count
//   clear   : restart the count (wins over tick)
//   tick    : one more cycle spent waiting (mem_ready low in a wait state)
//   expired : combinational; the count already stands at MAX_WAIT and this
//             cycle is still a waiting one, so the wait has timed out
// The count saturates at MAX_WAIT and never wraps.
`timescale 1ns/1ps
module ctrl_wait_timer
  import multicycle_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (tick && (count_q != MAX_CNT)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Ready in the same cycle the count sits at MAX_WAIT drops tick, so a
  // late completion still succeeds.
  assign expired = tick && (count_q == MAX_CNT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore controller for a multicycle datapath
// (fetch / decode / execute / memory / writeback).
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   opcode[5:0]       : instruction register bits [31:26]
//   mem_ready         : memory finished the current access this cycle
//   IR_W              : 1 = IR holds, 0 = IR captures at the next edge
//   pc_we, pc_we_cond : unconditional / zero-qualified PC write
//   iord              : memory address select (0 = PC, 1 = ALUOut)
//   mem_rd, mem_wr    : memory strobes
//   reg_we, reg_dst, mem_to_reg : register file write controls
//   alu_src_a, alu_src_b, alu_op, pc_src : datapath selects
//   fault             : sticky illegal-opcode / memory-timeout flag
// Optional build macro MULTICYCLE_CTRL_PERF_EN adds instr_retired[31:0]
// and cycle_count[31:0] performance counters.
`timescale 1ns/1ps
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       IR_W,
  output logic       pc_we,
  output logic       pc_we_cond,
  output logic       iord,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       reg_we,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       fault
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] instr_retired,
  output logic [31:0] cycle_count
`endif
);

  state_t state_q, state_d;
  logic   fault_q, fault_d;
  logic   wait_tick, wait_clear, wait_expired;

  assign wait_tick  = is_wait_state(state_q) && !mem_ready;
  // Any state change restarts the count, so every wait state is entered
  // with a fresh budget (including MEMWR -> FETCH).
  assign wait_clear = (state_d != state_q) || !is_wait_state(state_q);

  ctrl_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .WAIT_W   (WAIT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wait_clear),
    .tick    (wait_tick),
    .expired (wait_expired)
  );

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)         state_d = S_DECODE;
        else if (wait_expired) state_d = S_HALT;
      end
      S_DECODE: begin
        unique case (opcode)
          OP_RTYPE:     state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_HALT;
        endcase
      end
      S_EXEC:    state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      // IR is held after fetch, so opcode still names lw or sw here.
      S_MEMADR:  state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (mem_ready)         state_d = S_MEMWB;
        else if (wait_expired) state_d = S_HALT;
      end
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR: begin
        if (mem_ready)         state_d = S_FETCH;
        else if (wait_expired) state_d = S_HALT;
      end
      S_BRANCH:  state_d = S_FETCH;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_ADDI_WB: state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_HALT;
    endcase
  end

  assign fault_d = fault_q || (state_d == S_HALT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // Output decode (Moore except the fetch-completion qualification)
  always_comb begin
    IR_W       = 1'b1;
    pc_we      = 1'b0;
    pc_we_cond = 1'b0;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op     = ALU_ADD;
    pc_src     = PC_ALU;
    unique case (state_q)
      S_IDLE: alu_src_b = SRCB_FOUR;
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = SRCB_FOUR;
        // Capture IR and advance PC only in the cycle the read completes.
        IR_W      = !mem_ready;
        pc_we     = mem_ready;
      end
      S_DECODE: alu_src_b = SRCB_IMM_SH;
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        reg_we  = 1'b1;
        reg_dst = 1'b1;
      end
      S_MEMADR, S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
      end
      S_MEMWB: begin
        reg_we     = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_we_cond = 1'b1;
        pc_src     = PC_ALUOUT;
      end
      S_ADDI_WB: reg_we = 1'b1;
      S_JUMP: begin
        pc_we  = 1'b1;
        pc_src = PC_JUMP;
      end
      default: ;
    endcase
  end

  assign fault = fault_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] instr_retired_q, instr_retired_d;
  logic [31:0] cycle_count_q, cycle_count_d;

  always_comb begin
    cycle_count_d   = cycle_count_q;
    instr_retired_d = instr_retired_q;
    if ((state_q != S_IDLE) && (state_q != S_HALT)) begin
      cycle_count_d = cycle_count_q + 32'd1;
    end
    // Entering fetch from anything but idle or fetch ends an instruction.
    if ((state_d == S_FETCH) && (state_q != S_IDLE) && (state_q != S_FETCH)) begin
      instr_retired_d = instr_retired_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cycle_count_q   <= '0;
      instr_retired_q <= '0;
    end else begin
      cycle_count_q   <= cycle_count_d;
      instr_retired_q <= instr_retired_d;
    end
  end

  assign instr_retired = instr_retired_q;
  assign cycle_count   = cycle_count_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: scoreboard bench for multicycle_ctrl. The stimulus
// process pushes the expected control word for every cycle it drives; a
// monitor on the falling edge pops and compares under a per-state care mask.
`timescale 1ns/1ps
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       IR_W, pc_we, pc_we_cond, iord, mem_rd, mem_wr;
  logic       reg_we, reg_dst, mem_to_reg, alu_src_a, fault;
  logic [1:0] alu_src_b, alu_op, pc_src;
`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] instr_retired, cycle_count;
`endif

  always #5 clk = ~clk;

  multicycle_ctrl #(.MAX_WAIT(15), .WAIT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .mem_ready  (mem_ready),
    .IR_W       (IR_W),
    .pc_we      (pc_we),
    .pc_we_cond (pc_we_cond),
    .iord       (iord),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .reg_we     (reg_we),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .pc_src     (pc_src),
    .fault      (fault)
`ifdef MULTICYCLE_CTRL_PERF_EN
    ,
    .instr_retired (instr_retired),
    .cycle_count   (cycle_count)
`endif
  );

  typedef struct {
    logic [16:0] v;
    logic [16:0] m;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;

  localparam int T_IDLE = 0,  T_FW = 1,     T_FG = 2,     T_DEC = 3;
  localparam int T_EXEC = 4,  T_ALUWB = 5,  T_MEMADR = 6, T_MEMRD = 7;
  localparam int T_MEMWB = 8, T_MEMWR = 9,  T_BR = 10,    T_ADDIEX = 11;
  localparam int T_ADDIWB = 12, T_JUMP = 13, T_HALT = 14;

  // Word layout: IR_W pc_we pc_we_cond iord mem_rd mem_wr reg_we reg_dst
  //              mem_to_reg alu_src_a alu_src_b[2] alu_op[2] pc_src[2] fault
  function automatic logic [16:0] ev(
    input logic irw, pcwe, pcwc, io, rd, wr, rwe, rdst, m2r, asa,
    input logic [1:0] asb, aop, psrc,
    input logic flt);
    return {irw, pcwe, pcwc, io, rd, wr, rwe, rdst, m2r, asa, asb, aop, psrc, flt};
  endfunction

  function automatic exp_t exp_for(input int s, input string name);
    exp_t e;
    logic [16:0] ms, m_io, m_rdst, m_m2r, m_asa, m_asb, m_aop, m_psrc;
    ms     = ev(1,1,1,0,1,1,1,0,0,0,2'b00,2'b00,2'b00,1);
    m_io   = ev(0,0,0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0);
    m_rdst = ev(0,0,0,0,0,0,0,1,0,0,2'b00,2'b00,2'b00,0);
    m_m2r  = ev(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0);
    m_asa  = ev(0,0,0,0,0,0,0,0,0,1,2'b00,2'b00,2'b00,0);
    m_asb  = ev(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0);
    m_aop  = ev(0,0,0,0,0,0,0,0,0,0,2'b00,2'b11,2'b00,0);
    m_psrc = ev(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b11,0);
    e.name = name;
    e.v    = '0;
    e.m    = ms;
    case (s)
      T_IDLE:   begin e.v = ev(1,0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0); e.m = '1; end
      T_FW:     begin e.v = ev(1,0,0,0,1,0,0,0,0,0,2'b01,2'b00,2'b00,0); e.m = ms|m_io|m_asa|m_asb|m_aop|m_psrc; end
      T_FG:     begin e.v = ev(0,1,0,0,1,0,0,0,0,0,2'b01,2'b00,2'b00,0); e.m = ms|m_io|m_asa|m_asb|m_aop|m_psrc; end
      T_DEC:    begin e.v = ev(1,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0); e.m = ms|m_asa|m_asb|m_aop; end
      T_EXEC:   begin e.v = ev(1,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0); e.m = ms|m_asa|m_asb|m_aop; end
      T_ALUWB:  begin e.v = ev(1,0,0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00,0); e.m = ms|m_rdst|m_m2r; end
      T_MEMADR: begin e.v = ev(1,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0); e.m = ms|m_asa|m_asb|m_aop; end
      T_MEMRD:  begin e.v = ev(1,0,0,1,1,0,0,0,0,0,2'b00,2'b00,2'b00,0); e.m = ms|m_io; end
      T_MEMWB:  begin e.v = ev(1,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0); e.m = ms|m_rdst|m_m2r; end
      T_MEMWR:  begin e.v = ev(1,0,0,1,0,1,0,0,0,0,2'b00,2'b00,2'b00,0); e.m = ms|m_io; end
      T_BR:     begin e.v = ev(1,0,1,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0); e.m = ms|m_asa|m_asb|m_aop|m_psrc; end
      T_ADDIEX: begin e.v = ev(1,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0); e.m = ms|m_asa|m_asb|m_aop; end
      T_ADDIWB: begin e.v = ev(1,0,0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,0); e.m = ms|m_rdst|m_m2r; end
      T_JUMP:   begin e.v = ev(1,1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0); e.m = ms|m_psrc; end
      T_HALT:   begin e.v = ev(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,1); e.m = ms; end
      default:  begin e.v = '0; e.m = '1; end
    endcase
    return e;
  endfunction

  // Called just after a rising edge: drive this cycle's inputs, queue the
  // outputs required during it, then advance one cycle.
  task automatic step(input logic rn, input logic mr, input logic [5:0] op,
                      input int s, input string name);
    rst_n     = rn;
    mem_ready = mr;
    opcode    = op;
    sb_q.push_back(exp_for(s, name));
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input int waits, input logic [5:0] op);
    for (int i = 0; i < waits; i++) step(1'b1, 1'b0, op, T_FW, "fetch_wait");
    step(1'b1, 1'b1, op, T_FG, "fetch_go");
  endtask

  // mem_ready is held high in non-wait states to show it is ignored there.
  task automatic run_instr(input logic [5:0] op, input int fwaits);
    fetch(fwaits, op);
    step(1'b1, 1'b1, op, T_DEC, "decode");
    case (op)
      6'h00: begin
        step(1'b1, 1'b1, op, T_EXEC, "r_exec");
        step(1'b1, 1'b1, op, T_ALUWB, "r_wb");
      end
      6'h08: begin
        step(1'b1, 1'b1, op, T_ADDIEX, "addi_ex");
        step(1'b1, 1'b1, op, T_ADDIWB, "addi_wb");
      end
      6'h23: begin
        step(1'b1, 1'b1, op, T_MEMADR, "lw_adr");
        step(1'b1, 1'b1, op, T_MEMRD, "lw_rd");
        step(1'b1, 1'b1, op, T_MEMWB, "lw_wb");
      end
      6'h2B: begin
        step(1'b1, 1'b1, op, T_MEMADR, "sw_adr");
        step(1'b1, 1'b1, op, T_MEMWR, "sw_wr");
      end
      6'h04: step(1'b1, 1'b1, op, T_BR, "beq");
      6'h02: step(1'b1, 1'b1, op, T_JUMP, "jump");
      default: ;
    endcase
  endtask

  exp_t        mon_e;
  logic [16:0] mon_act;

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e   = sb_q.pop_front();
      mon_act = {IR_W, pc_we, pc_we_cond, iord, mem_rd, mem_wr, reg_we, reg_dst,
                 mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_src, fault};
      tests++;
      if ((mon_act & mon_e.m) !== (mon_e.v & mon_e.m)) begin
        fails++;
        $display("FAIL %s @%0t: got %b required %b (care %b)",
                 mon_e.name, $time, mon_act, mon_e.v, mon_e.m);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    opcode    = 6'h00;
    @(posedge clk);
    #1;
    // Reset and first fetch
    step(1'b0, 1'b0, 6'h00, T_IDLE, "reset_idle");
    step(1'b1, 1'b1, 6'h00, T_IDLE, "idle_release");
    // Opcode sequence, zero wait states; the lw fetch is the first fetch
    run_instr(6'h23, 0);
    run_instr(6'h2B, 0);
    run_instr(6'h04, 0);
    run_instr(6'h02, 0);
    // Fetch with three wait cycles, then R-type and addi
    run_instr(6'h00, 3);
    run_instr(6'h08, 0);

    // Store timeout: 15 waiting cycles build the count, the 16th expires
    fetch(0, 6'h2B);
    step(1'b1, 1'b0, 6'h2B, T_DEC, "to_decode");
    step(1'b1, 1'b0, 6'h2B, T_MEMADR, "to_adr");
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 6'h2B, T_MEMWR, "to_memwr");
    step(1'b1, 1'b0, 6'h2B, T_HALT, "to_halt");
    step(1'b1, 1'b1, 6'h2B, T_HALT, "to_halt_ready");
    step(1'b0, 1'b0, 6'h2B, T_HALT, "to_halt_in_reset");
    step(1'b1, 1'b1, 6'h2B, T_IDLE, "to_idle_after");

    // Same store, memory answers exactly when the count is at 15
    fetch(0, 6'h2B);
    step(1'b1, 1'b0, 6'h2B, T_DEC, "late_decode");
    step(1'b1, 1'b0, 6'h2B, T_MEMADR, "late_adr");
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 6'h2B, T_MEMWR, "late_memwr_wait");
    step(1'b1, 1'b1, 6'h2B, T_MEMWR, "late_memwr_ready");
    run_instr(6'h04, 0);

    // Illegal opcode halts until reset
    fetch(0, 6'h3F);
    step(1'b1, 1'b0, 6'h3F, T_DEC, "ill_decode");
    for (int i = 0; i < 4; i++) step(1'b1, 1'(i), 6'h3F, T_HALT, "ill_halt");
    step(1'b0, 1'b1, 6'h3F, T_HALT, "ill_halt_in_reset");
    step(1'b1, 1'b0, 6'h3F, T_IDLE, "ill_idle_after");

    // Reset while a load waits in the read state
    fetch(1, 6'h23);
    step(1'b1, 1'b0, 6'h23, T_DEC, "midlw_decode");
    step(1'b1, 1'b0, 6'h23, T_MEMADR, "midlw_adr");
    step(1'b1, 1'b0, 6'h23, T_MEMRD, "midlw_rd");
    step(1'b0, 1'b1, 6'h23, T_MEMRD, "midlw_rd_in_reset");
    step(1'b1, 1'b1, 6'h23, T_IDLE, "midlw_idle");
    run_instr(6'h00, 0);

    @(negedge clk);
    #1;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style FSM that sequences the multicycle datapath: fetch, decode, execute, memory and writeback.
- Drives the instruction register capture strobe, PC update, memory strobes and datapath mux selects.
- Waits on a memory-ready handshake, with a bounded wait.
- Sits beside the instruction register; its opcode input comes from that register's output bits [31:26].

Parameters:
- MAX_WAIT, 15: maximum cycles a memory strobe may wait for mem_ready before the FSM faults (1..255).
- WAIT_W, 8: width of the wait counter.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- opcode  input  6  instruction bits [31:26] from the instruction register.
- mem_ready  input  1  memory completed the current read or write this cycle.
- IR_W  output  1  instruction register hold strobe: 1 = hold, 0 = capture DataIn on the next clk edge.
- pc_we  output  1  unconditional PC write.
- pc_we_cond  output  1  PC write qualified by ALU zero (beq).
- iord  output  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_rd  output  1  memory read strobe.
- mem_wr  output  1  memory write strobe.
- reg_we  output  1  register file write.
- reg_dst  output  1  0 = rt, 1 = rd.
- mem_to_reg  output  1  0 = ALUOut, 1 = MDR.
- alu_src_a  output  1  0 = PC, 1 = A.
- alu_src_b  output  2  00 = B, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate.
- alu_op  output  2  00 = add, 01 = sub, 10 = funct, 11 = reserved.
- pc_src  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- fault  output  1  sticky flag: illegal opcode or memory timeout.

Behaviour:
- Reset
  - rst_n=0 at an edge sends the FSM to S_IDLE, clears the wait counter and clears fault.
  - Reset mid-operation abandons the instruction; no write strobe is issued after that edge.
  - In S_IDLE all outputs are 0, except IR_W=1 and alu_src_b=01.
  - S_IDLE goes to S_FETCH on the next edge with rst_n=1.
- S_FETCH
  - Drives mem_rd=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - While mem_ready=0: IR_W=1 and pc_we=0, and the FSM stays in S_FETCH.
  - In the cycle mem_ready=1: IR_W=0 and pc_we=1 (Mealy qualification), then go to S_DECODE.
  - IR_W is low for exactly one cycle per instruction.
- S_DECODE
  - Drives alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Opcode dispatch:
    - 000000 R-type -> S_EXEC
    - 100011 lw or 101011 sw -> S_MEMADR
    - 000100 beq -> S_BRANCH
    - 001000 addi -> S_ADDI_EX
    - 000010 j -> S_JUMP
    - anything else -> S_HALT with fault=1.
- S_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; -> S_ALUWB.
- S_ALUWB: reg_we=1, reg_dst=1, mem_to_reg=0; -> S_FETCH.
- S_MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; -> S_MEMRD for lw, S_MEMWR for sw.
- S_MEMRD: mem_rd=1, iord=1; hold until mem_ready=1; -> S_MEMWB.
- S_MEMWB: reg_we=1, reg_dst=0, mem_to_reg=1; -> S_FETCH.
- S_MEMWR: mem_wr=1, iord=1; hold until mem_ready=1; -> S_FETCH.
- S_BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_we_cond=1, pc_src=01; -> S_FETCH.
- S_ADDI_EX: alu_src_a=1, alu_src_b=10, alu_op=00; -> S_ADDI_WB.
- S_ADDI_WB: reg_we=1, reg_dst=0, mem_to_reg=0; -> S_FETCH.
- S_JUMP: pc_we=1, pc_src=10; -> S_FETCH.
- S_HALT
  - All strobes 0 and IR_W=1.
  - The FSM leaves only on reset; fault stays 1.
- Wait counter
  - Clears on entry to any wait state (S_FETCH, S_MEMRD, S_MEMWR).
  - Increments each cycle that mem_ready=0.
  - If the count reaches MAX_WAIT with mem_ready still 0: next state is S_HALT, fault=1, and no write strobe is issued.
  - mem_ready=1 in the same cycle the count reaches MAX_WAIT counts as success (ready wins).
  - The counter saturates and never wraps.
- mem_ready outside a wait state is ignored.
- mem_rd and mem_wr are never 1 in the same cycle.
- Cycle counts per instruction, with zero wait states:
  - R-type and addi: 4
  - lw: 5
  - sw: 4
  - beq and j: 3

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_EN.
- Defined: adds outputs instr_retired[31:0] and cycle_count[31:0].
  - Both clear on reset and wrap at 2^32.
  - cycle_count increments every cycle outside S_IDLE and S_HALT.
  - instr_retired increments on each transition into S_FETCH from a completing state.
- Undefined: neither port nor either counter exists; all other behaviour is identical.

Decomposition:
- Package multicycle_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J)
  - the state enumeration
  - alu_op, alu_src_b and pc_src encodings.
- Sub-module ctrl_wait_timer holds the wait counter.
  - Inputs: clk, rst_n, clear, tick, MAX_WAIT parameter.
  - Output: expired.

Test Plan:
- Reset and first fetch: hold rst_n=0 for 2 cycles, then release with mem_ready=1 -> IR_W=1 and all strobes 0 in S_IDLE; the next cycle shows mem_rd=1, IR_W=0, pc_we=1.
- Fetch wait: mem_ready=0 for 3 cycles, then 1 -> IR_W=1 and pc_we=0 for 3 cycles, then exactly one cycle of IR_W=0 and pc_we=1.
- Opcode sequence with zero wait states:
  - lw (0x23): 5 cycles, reg_we in cycle 5 with mem_to_reg=1.
  - sw (0x2B): 4 cycles, mem_wr in cycle 4.
  - beq (0x04): 3 cycles, pc_we_cond in cycle 3.
  - j (0x02): 3 cycles, pc_src=10.
- Illegal opcode 0x3F -> S_HALT after decode, fault=1, IR_W stuck at 1; only rst_n=0 clears it.
- Timeout: S_MEMWR with mem_ready held 0, MAX_WAIT=15 -> fault after 15 wait cycles, no further mem_wr; a repeat run with mem_ready=1 exactly at count 15 completes normally.
- Reset mid-lw in S_MEMRD -> S_IDLE at the next edge, reg_we never asserted, fault=0.
